alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Width is generic, and the opcode set gains MUL (iterative shift-add, full double-width product) and ROT.
- Results and flags are registered and presented on a valid/ready output channel, so the ALU can sit behind a stalling decode stage and ahead of a stalling writeback stage.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of two, minimum 4.
- SHAMT_W, $clog2(WIDTH), shift/rotate/bit-select amount width (derived, do not override).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  ALU can accept a request this cycle.
- alu_op  in  4  opcode, sampled at accept.
- alu_port_A  in  WIDTH  operand A, sampled at accept.
- alu_port_B  in  WIDTH  operand B, sampled at accept.
- alu_shift_dir  in  1  1 = right, 0 = left (SHIFT, ROT), sampled at accept.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  WIDTH  result; low half of the product for MUL.
- alu_out_hi  out  WIDTH  high half of the product for MUL; 0 for every other op.
- alu_carry  out  1  ADD carry-out; SUB borrow (A<B unsigned); 0 otherwise.
- alu_zero  out  1  1 when alu_out == 0; alu_out_hi ignored.

Behaviour:
- Opcodes: ADD=0, SUB=1, XORMT=2, ANDMT=3, AND=4, OR=5, XOR=6, SHIFT=7, SSB=8, PASSB=9, MUL=10, ROT=11; 12-15 are undefined.
- ADD/SUB: mod 2^WIDTH; carry/borrow on alu_carry.
- XORMT: {0.., ^(A&B)}.
- ANDMT: {0.., &(A | ~B)}, i.e. 1 when every bit set in B is set in A.
- AND/OR/XOR: bitwise.
- SHIFT: logical shift of A by B[SHAMT_W-1:0]; zero fill.
- SSB: {0.., A[B[SHAMT_W-1:0]]}, a true bit test.
- PASSB: B.
- ROT: rotate A by B[SHAMT_W-1:0]; direction per alu_shift_dir.
- MUL: unsigned A*B, 2*WIDTH bits; {alu_out_hi, alu_out} = product.
- Undefined ops: result 0, carry 0, zero 1; single-cycle.
- State machine IDLE / BUSY / DONE:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - Accept = in_valid & in_ready.
- IDLE, accept, non-MUL op: result and flags registered at that edge; -> DONE. out_valid is high the cycle after accept (latency 1).
- IDLE, accept, MUL: capture A, B; clear accumulator; count = 0; -> BUSY.
- BUSY: one multiplier bit per cycle, LSB first: if B[count], acc += A << count. Count increments each cycle.
  - After exactly WIDTH BUSY cycles, the product is written to the output registers and the FSM goes -> DONE.
  - out_valid rises WIDTH+1 cycles after accept.
- DONE:
  - Outputs are held stable while out_ready = 0; arbitrary stall length.
  - out_ready = 1: -> IDLE next cycle.
  - No new accept in the DONE cycle. Peak throughput is one op per 2 cycles (single-cycle ops).
- Input sampling: inputs are sampled only at accept. Changes to inputs during BUSY/DONE have no effect.
- in_valid while not ready: ignored; the requester must hold the request until accepted.
- Reset (rst_n=0 at a rising edge), in any state including mid-MUL:
  - State -> IDLE.
  - alu_out, alu_out_hi, alu_carry = 0; alu_zero = 1.
  - out_valid = 0, count = 0.
  - Any in-flight operation is discarded. in_ready is 1 from the first cycle after rst_n returns high.
- Flags are registered with the result and change only on transition into DONE or on reset.

Test Plan (WIDTH=8):
1. ADD, A=0xF0, B=0x20, out_ready=1 -> out_valid high 1 cycle after accept; alu_out=0x10, alu_carry=1, alu_zero=0, alu_out_hi=0x00.
2. SUB, A=0x05, B=0x07 -> alu_out=0xFE, alu_carry=1. Then SUB, A=0x07, B=0x07 -> alu_out=0x00, alu_carry=0, alu_zero=1.
3. MUL, A=200, B=3 -> in_ready low for 9 cycles; out_valid at cycle 9 after accept; alu_out=0x58, alu_out_hi=0x02. MUL, A=0xFF, B=0xFF -> alu_out=0x01, alu_out_hi=0xFE.
4. ROT/SSB, A=0x81: ROT dir=1, B=1 -> alu_out=0xC0. ROT dir=0, B=9 (amount 1) -> 0x03. SSB, B=7 -> 0x01. SSB, B=3 -> 0x00.
5. Backpressure: OR, A=0x0F, B=0x30, out_ready=0 for 5 cycles -> alu_out=0x3F held, out_valid held, in_ready=0 throughout. Operand inputs toggled during the stall must not change the outputs. out_ready=1 -> IDLE; in_ready=1 the next cycle.
6. Reset mid-MUL: accept MUL A=0x0D, B=0x0B; drive rst_n=0 on BUSY cycle 3 -> next cycle state IDLE, out_valid=0, alu_out=0, alu_zero=1. Then a fresh MUL 13*11 -> alu_out=0x8F, alu_out_hi=0x00 (no residue from the aborted op).

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked, parametrised ALU. Single-cycle ops (ADD, SUB, XORMT,
//            ANDMT, AND, OR, XOR, SHIFT, SSB, PASSB, ROT) register their
//            result one cycle after accept; MUL runs an iterative shift-add
//            over WIDTH cycles and returns the full double-width product.
//            Results and flags sit in registers behind a valid/ready channel.
// Ports    : clk, rst_n (sync, active low)
//            in_valid / in_ready        request handshake
//            alu_op, alu_port_A/B, alu_shift_dir   sampled at accept
//            out_valid / out_ready      result handshake
//            alu_out, alu_out_hi        result (hi = MUL upper half, else 0)
//            alu_carry, alu_zero        flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_port_A,
    input  logic [WIDTH-1:0] alu_port_B,
    input  logic             alu_shift_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             alu_carry,
    output logic             alu_zero
);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_XORMT = 4'd2;
    localparam logic [3:0] c_OP_ANDMT = 4'd3;
    localparam logic [3:0] c_OP_AND   = 4'd4;
    localparam logic [3:0] c_OP_OR    = 4'd5;
    localparam logic [3:0] c_OP_XOR   = 4'd6;
    localparam logic [3:0] c_OP_SHIFT = 4'd7;
    localparam logic [3:0] c_OP_SSB   = 4'd8;
    localparam logic [3:0] c_OP_PASSB = 4'd9;
    localparam logic [3:0] c_OP_MUL   = 4'd10;
    localparam logic [3:0] c_OP_ROT   = 4'd11;

    localparam logic [SHAMT_W-1:0] c_LAST_BIT = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_out;
    logic [WIDTH-1:0]     r_out_hi;
    logic                 r_carry;
    logic                 r_zero;

    logic [SHAMT_W-1:0]   w_amt;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_dbl;
    logic [2*WIDTH-1:0]   w_rot_r;
    logic [2*WIDTH-1:0]   w_rot_l;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_amt  = alu_port_B[SHAMT_W-1:0];
    assign w_sum  = {1'b0, alu_port_A} + {1'b0, alu_port_B};
    // Extra top bit of the difference is the unsigned borrow (A < B).
    assign w_diff = {1'b0, alu_port_A} - {1'b0, alu_port_B};

    // Rotation via a doubled copy of A: right rotate reads the low half after
    // shifting right, left rotate reads the high half after shifting left.
    assign w_dbl   = {alu_port_A, alu_port_A};
    assign w_rot_r = w_dbl >> w_amt;
    assign w_rot_l = w_dbl << w_amt;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (alu_op)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            c_OP_XORMT: w_res = {{(WIDTH-1){1'b0}}, ^(alu_port_A & alu_port_B)};
            c_OP_ANDMT: w_res = {{(WIDTH-1){1'b0}}, &(alu_port_A | ~alu_port_B)};
            c_OP_AND:   w_res = alu_port_A & alu_port_B;
            c_OP_OR:    w_res = alu_port_A | alu_port_B;
            c_OP_XOR:   w_res = alu_port_A ^ alu_port_B;
            c_OP_SHIFT: w_res = alu_shift_dir ? (alu_port_A >> w_amt)
                                              : (alu_port_A << w_amt);
            c_OP_SSB:   w_res = {{(WIDTH-1){1'b0}}, alu_port_A[w_amt]};
            c_OP_PASSB: w_res = alu_port_B;
            c_OP_ROT:   w_res = alu_shift_dir ? w_rot_r[WIDTH-1:0]
                                              : w_rot_l[2*WIDTH-1:WIDTH];
            default:    w_res = '0;
        endcase
    end

    // Shift-add step: partial product of A aligned to the current multiplier bit.
    assign w_pp       = {{WIDTH{1'b0}}, r_mul_a} << r_count;
    assign w_acc_next = r_mul_b[r_count] ? (r_acc + w_pp) : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_out_hi <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (alu_op == c_OP_MUL) begin
                            r_mul_a <= alu_port_A;
                            r_mul_b <= alu_port_B;
                            r_acc   <= '0;
                            r_count <= '0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_out    <= w_res;
                            r_out_hi <= '0;
                            r_carry  <= w_carry;
                            r_zero   <= (w_res == '0);
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST_BIT) begin
                        r_out    <= w_acc_next[WIDTH-1:0];
                        r_out_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_carry  <= 1'b0;
                        r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign alu_out    = r_out;
    assign alu_out_hi = r_out_hi;
    assign alu_carry  = r_carry;
    assign alu_zero   = r_zero;

endmodule
`default_nettype wire
